k2_pc_sequencer: RTL and testbench

Program-counter and instruction-phase sequencer for the K2 core, directly upstream and downstream of the jump/carry/flag decision logic. Holds the PC and generates the two-phase step bit `s_reg` that the decision logic consumes. Consumes the resulting `jcf` to choose between a branch to `target` and sequential advance. Also provides run/halt control and an optional call/return stack.

---
 rtl/k2_pkg.sv | 20 ++
 rtl/k2_ret_stack.sv | 61 ++++++
 rtl/k2_pc_sequencer.sv | 128 ++++++++++++
 tb/tb_k2_pc_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/k2_pkg.sv
// +----------------------------------------------------------------------------+
// | k2_pkg : shared types and default sizes for the K2 PC sequencer            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package k2_pkg;

  localparam int K2_PC_W        = 4;
  localparam int K2_STACK_DEPTH = 4;

  typedef enum logic [1:0] {
    PH0  = 2'd0,
    PH1  = 2'd1,
    HALT = 2'd2
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/k2_ret_stack.sv
// +----------------------------------------------------------------------------+
// | k2_ret_stack : circular return-address LIFO with sticky error flag        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module k2_ret_stack
  import k2_pkg::*;
#(
  parameter int DEPTH = K2_STACK_DEPTH,
  parameter int W     = K2_PC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic         err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W:0]   count;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = empty ? '0 : mem[ptr - PTR_W'(1)];

  // When full, ptr already points at the oldest entry, so a push overwrites it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      err   <= 1'b0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (full) err   <= 1'b1;
      else      count <= count + (PTR_W+1)'(1);
    end else if (pop) begin
      if (empty) begin
        err <= 1'b1;
      end else begin
        ptr   <= ptr - PTR_W'(1);
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

  // Contents survive reset; only the pointer is cleared.
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/k2_pc_sequencer.sv
// +----------------------------------------------------------------------------+
// | k2_pc_sequencer : K2 program counter and two-phase step sequencer          |
// | Optional call/return stack enabled by macro K2_CALL_STACK_EN               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module k2_pc_sequencer
  import k2_pkg::*;
#(
  parameter int PC_W        = K2_PC_W,
  parameter int STACK_DEPTH = K2_STACK_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            instr_multi,
  input  logic            instr_halt,
`ifdef K2_CALL_STACK_EN
  input  logic            instr_call,
  input  logic            instr_ret,
`endif
  input  logic            jcf,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc,
  output logic            s_reg,
  output logic            halted,
`ifdef K2_CALL_STACK_EN
  output logic            stack_err,
`endif
  output logic            pc_wrap
);

  localparam logic [1:0] ST_PH0  = PH0;
  localparam logic [1:0] ST_PH1  = PH1;
  localparam logic [1:0] ST_HALT = HALT;

  generate
    if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("STACK_DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [1:0]      state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            wrap_nxt;
  logic [PC_W:0]   pc_inc;

  assign pc_inc = {1'b0, pc} + (PC_W+1)'(1);
  assign s_reg  = state[0];

`ifdef K2_CALL_STACK_EN
  logic            push, pop;
  logic [PC_W-1:0] pop_data;
  logic            stk_full, stk_empty;

  k2_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc[PC_W-1:0]),
    .pop_data  (pop_data),
    .full      (stk_full),
    .empty     (stk_empty),
    .err       (stack_err)
  );
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    wrap_nxt  = 1'b0;
`ifdef K2_CALL_STACK_EN
    push      = 1'b0;
    pop       = 1'b0;
`endif
    if (en) begin
      case (state)
        ST_PH0: begin
          if (instr_halt) begin
            state_nxt = ST_HALT;
`ifdef K2_CALL_STACK_EN
          end else if (instr_call) begin
            push   = 1'b1;
            pc_nxt = target;
          end else if (instr_ret) begin
            pop    = 1'b1;
            pc_nxt = pop_data;
`endif
          end else if (jcf) begin
            pc_nxt = target;
          end else if (instr_multi) begin
            state_nxt = ST_PH1;
          end else begin
            {wrap_nxt, pc_nxt} = pc_inc;
          end
        end
        ST_PH1: begin
          state_nxt = ST_PH0;
          if (jcf) pc_nxt = target;
          else     {wrap_nxt, pc_nxt} = pc_inc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_PH0;
      pc      <= '0;
      halted  <= 1'b0;
      pc_wrap <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      halted  <= (state_nxt == ST_HALT);
      pc_wrap <= wrap_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_k2_pc_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_k2_pc_sequencer : directed self-checking bench for k2_pc_sequencer      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_k2_pc_sequencer;

  localparam int PC_W = 4;

  logic            clk = 1'b0;
  logic            rst, en, instr_multi, instr_halt, jcf;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc;
  logic            s_reg, halted, pc_wrap;
`ifdef K2_CALL_STACK_EN
  logic            instr_call, instr_ret, stack_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  k2_pc_sequencer #(.PC_W(PC_W), .STACK_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .instr_multi (instr_multi),
    .instr_halt  (instr_halt),
`ifdef K2_CALL_STACK_EN
    .instr_call  (instr_call),
    .instr_ret   (instr_ret),
    .stack_err   (stack_err),
`endif
    .jcf         (jcf),
    .target      (target),
    .pc          (pc),
    .s_reg       (s_reg),
    .halted      (halted),
    .pc_wrap     (pc_wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic jump_to(input logic [PC_W-1:0] t);
    jcf = 1'b1; target = t;
    step();
    jcf = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; instr_multi = 1'b0; instr_halt = 1'b0;
    jcf = 1'b0; target = '0;
`ifdef K2_CALL_STACK_EN
    instr_call = 1'b0; instr_ret = 1'b0;
`endif
    @(negedge clk);
    step();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_s", 32'(s_reg), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_wrap", 32'(pc_wrap), 0);
`ifdef K2_CALL_STACK_EN
    chk("rst_err", 32'(stack_err), 0);
`endif

    // Sequential advance through a full wrap.
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("seq_pc", 32'(pc), 32'((i + 1) % 16));
      chk("seq_wrap", 32'(pc_wrap), (i == 15) ? 32'd1 : 32'd0);
    end
    step();
    chk("wrap_one_cycle", 32'(pc_wrap), 0);

    // Multi-phase at pc=5.
    jump_to(4'd5);
    chk("jmp5_pc", 32'(pc), 5);
    instr_multi = 1'b1;
    step();
    chk("multi_s1", 32'(s_reg), 1);
    chk("multi_pc_hold", 32'(pc), 5);
    step();
    instr_multi = 1'b0;
    chk("multi_s0", 32'(s_reg), 0);
    chk("multi_pc_adv", 32'(pc), 6);

    // PH1 with jump taken and not taken.
    jump_to(4'd3);
    instr_multi = 1'b1; step(); instr_multi = 1'b0;
    chk("ph1a_s", 32'(s_reg), 1);
    jump_to(4'd9);
    chk("ph1_jmp_pc", 32'(pc), 9);
    chk("ph1_jmp_s", 32'(s_reg), 0);
    jump_to(4'd3);
    instr_multi = 1'b1; step();
    step();
    instr_multi = 1'b0;
    chk("ph1_seq_pc", 32'(pc), 4);
    chk("ph1_seq_s", 32'(s_reg), 0);

    // Enable low holds everything.
    en = 1'b0; jcf = 1'b1; target = 4'd12;
    step();
    chk("en0_pc", 32'(pc), 4);
    chk("en0_wrap", 32'(pc_wrap), 0);
    jcf = 1'b0; en = 1'b1;

    // Jump to 0 from 15 does not pulse wrap; self-loop repeats.
    jump_to(4'd15);
    jump_to(4'd0);
    chk("jmp0_pc", 32'(pc), 0);
    chk("jmp0_wrap", 32'(pc_wrap), 0);
    jump_to(4'd0);
    jump_to(4'd0);
    chk("selfloop_pc", 32'(pc), 0);

    // HALT at 7 is absorbing.
    jump_to(4'd7);
    instr_halt = 1'b1;
    step();
    instr_halt = 1'b0;
    chk("halt_flag", 32'(halted), 1);
    chk("halt_pc", 32'(pc), 7);
    jcf = 1'b1; target = 4'd3; instr_multi = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("halt_hold_pc", 32'(pc), 7);
    chk("halt_hold_flag", 32'(halted), 1);
    jcf = 1'b0; instr_multi = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk("halt_rst_pc", 32'(pc), 0);
    chk("halt_rst_flag", 32'(halted), 0);

    // Reset mid-instruction.
    jump_to(4'd2);
    instr_multi = 1'b1; step(); instr_multi = 1'b0;
    chk("ph1_pre_rst_s", 32'(s_reg), 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("ph1_rst_pc", 32'(pc), 0);
    chk("ph1_rst_s", 32'(s_reg), 0);

`ifdef K2_CALL_STACK_EN
    // Five CALLs overflow a depth-4 stack; oldest return (2) is lost.
    jump_to(4'd1);
    instr_call = 1'b1;
    for (int i = 0; i < 5; i++) begin
      target = 4'(8 + i);
      step();
      chk("call_pc", 32'(pc), 32'(8 + i));
      chk("call_err", 32'(stack_err), (i == 4) ? 32'd1 : 32'd0);
    end
    instr_call = 1'b0;
    instr_ret  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ret_pc", 32'(pc), 32'(12 - i));
    end
    jump_to(4'd6);
    step();
    chk("ret_empty_pc", 32'(pc), 0);
    chk("ret_empty_err", 32'(stack_err), 1);
    instr_ret = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk("err_rst", 32'(stack_err), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
